// File: rtl/operand_feeder.sv
// Reads A (2xK) then B (Kx2) from a 1-cycle-latency SRAM port and streams them
// as two AXI-Stream bursts through a 2-entry tagged FIFO with empty-bypass.
//
// state   | meaning
// IDLE    | waiting for start; rejects illegal cfg_k with an err pulse
// ISSUE_A | issuing the 2K reads of A
// ISSUE_B | issuing the 2K reads of B
// DRAIN   | all reads issued, waiting for the B TLAST handshake
module operand_feeder #(
    parameter int DATA_W = 32,
    parameter int K_MAX  = 64,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       cfg_k,
    input  logic [ADDR_W-1:0] cfg_a_base,
    input  logic [ADDR_W-1:0] cfg_b_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] m_axis_a_tdata,
    output logic              m_axis_a_tvalid,
    output logic              m_axis_a_tlast,
    input  logic              m_axis_a_tready,
    output logic [DATA_W-1:0] m_axis_b_tdata,
    output logic              m_axis_b_tvalid,
    output logic              m_axis_b_tlast,
    input  logic              m_axis_b_tready
);
    localparam int CNT_W = 17;

    typedef enum logic [1:0] {IDLE, ISSUE_A, ISSUE_B, DRAIN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   remaining;
    logic [CNT_W-1:0]   two_k;
    logic [ADDR_W-1:0]  ptr;
    logic [ADDR_W-1:0]  b_base_r;
    logic               en_stream, en_last;
    logic               rd_valid, rd_stream, rd_last;

    logic [DATA_W-1:0]  fifo_data   [2];
    logic               fifo_stream [2];
    logic               fifo_last   [2];
    logic               wr_ptr, rd_ptr;
    logic [1:0]         count;

    logic               head_valid, head_stream, head_last;
    logic [DATA_W-1:0]  head_data;
    logic               pop, push, pop_stored, issue_ok, k_ok;
    logic [2:0]         occ;

    // An empty FIFO passes the arriving read word straight to the head.
    always_comb begin
        head_valid  = (count != 2'd0) || rd_valid;
        head_data   = mem_rd_data;
        head_stream = rd_stream;
        head_last   = rd_last;
        if (count != 2'd0) begin
            head_data   = fifo_data[rd_ptr];
            head_stream = fifo_stream[rd_ptr];
            head_last   = fifo_last[rd_ptr];
        end
        pop        = head_valid && (head_stream ? m_axis_b_tready : m_axis_a_tready);
        pop_stored = pop && (count != 2'd0);
        push       = rd_valid && !((count == 2'd0) && pop);
        // Everything that will land in the FIFO: stored, arriving, and issued now.
        occ        = {1'b0, count} + {2'b0, rd_valid} + {2'b0, mem_rd_en};
        issue_ok   = (occ < 3'd2) || ((occ == 3'd2) && pop);
        k_ok       = (cfg_k != 16'd0) && (32'(cfg_k) <= K_MAX);
    end

    assign m_axis_a_tvalid = head_valid && !head_stream;
    assign m_axis_a_tdata  = m_axis_a_tvalid ? head_data : '0;
    assign m_axis_a_tlast  = m_axis_a_tvalid && head_last;
    assign m_axis_b_tvalid = head_valid && head_stream;
    assign m_axis_b_tdata  = m_axis_b_tvalid ? head_data : '0;
    assign m_axis_b_tlast  = m_axis_b_tvalid && head_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i]   <= '0;
                fifo_stream[i] <= 1'b0;
                fifo_last[i]   <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr]   <= mem_rd_data;
                fifo_stream[wr_ptr] <= rd_stream;
                fifo_last[wr_ptr]   <= rd_last;
                wr_ptr              <= ~wr_ptr;
            end
            if (pop_stored)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop_stored};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            remaining   <= '0;
            two_k       <= '0;
            ptr         <= '0;
            b_base_r    <= '0;
            en_stream   <= 1'b0;
            en_last     <= 1'b0;
            rd_valid    <= 1'b0;
            rd_stream   <= 1'b0;
            rd_last     <= 1'b0;
        end else begin
            done      <= 1'b0;
            err       <= 1'b0;
            mem_rd_en <= 1'b0;
            rd_valid  <= mem_rd_en;
            rd_stream <= en_stream;
            rd_last   <= en_last;
            case (state)
                IDLE: begin
                    // busy stays up through the done cycle, which is spent in IDLE
                    busy <= start && k_ok;
                    if (start && k_ok) begin
                        state       <= ISSUE_A;
                        two_k       <= {cfg_k, 1'b0};
                        remaining   <= {cfg_k, 1'b0} - CNT_W'(1);
                        b_base_r    <= cfg_b_base;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= cfg_a_base;
                        ptr         <= cfg_a_base + ADDR_W'(1);
                        en_stream   <= 1'b0;
                        en_last     <= 1'b0;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                ISSUE_A: begin
                    if (issue_ok) begin
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= ptr;
                        en_stream   <= 1'b0;
                        en_last     <= (remaining == CNT_W'(1));
                        if (remaining == CNT_W'(1)) begin
                            state     <= ISSUE_B;
                            ptr       <= b_base_r;
                            remaining <= two_k;
                        end else begin
                            ptr       <= ptr + ADDR_W'(1);
                            remaining <= remaining - CNT_W'(1);
                        end
                    end
                end
                ISSUE_B: begin
                    if (issue_ok) begin
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= ptr;
                        ptr         <= ptr + ADDR_W'(1);
                        en_stream   <= 1'b1;
                        en_last     <= (remaining == CNT_W'(1));
                        remaining   <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && head_stream && head_last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_operand_feeder.sv
// Bench for operand_feeder: SRAM model, per-cycle stream monitor and a
// queue-based reference of the expected address and beat sequences.
module tb_operand_feeder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cfg_k = '0;
    logic [15:0] cfg_a_base = '0;
    logic [15:0] cfg_b_base = '0;
    logic        busy, done, err, mem_rd_en;
    logic [15:0] mem_rd_addr;
    logic [31:0] mem_rd_data = '0;
    logic [31:0] a_tdata, b_tdata;
    logic        a_tvalid, a_tlast, b_tvalid, b_tlast;
    logic        a_tready = 1'b0;
    logic        b_tready = 1'b0;

    operand_feeder #(.DATA_W(32), .K_MAX(64), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_k(cfg_k),
        .cfg_a_base(cfg_a_base), .cfg_b_base(cfg_b_base),
        .busy(busy), .done(done), .err(err),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .m_axis_a_tdata(a_tdata), .m_axis_a_tvalid(a_tvalid),
        .m_axis_a_tlast(a_tlast), .m_axis_a_tready(a_tready),
        .m_axis_b_tdata(b_tdata), .m_axis_b_tvalid(b_tvalid),
        .m_axis_b_tlast(b_tlast), .m_axis_b_tready(b_tready)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          start_v = 0;
    int          ready_mode = 0;
    logic [31:0] seed = '0;
    logic [32:0] exp_a[$];
    logic [32:0] exp_b[$];
    logic [15:0] exp_addr[$];
    int          issued = 0, popped = 0, stall_reads = 0;
    int          first_rd_rel = -1, first_av_rel = -1, done_rel = -1, done_cnt = 0;
    bit          job_on = 0, err_test = 0, pa_stall = 0, pb_stall = 0;
    logic [33:0] pa_val = '0, pb_val = '0;
    logic        snap_err = 1'b0, snap_busy = 1'b0;

    function automatic logic [31:0] word(input logic [15:0] addr);
        return (seed * 32'h9E37_79B1) ^ {16'h0, addr};
    endfunction

    // SRAM: data for a strobed address appears the following cycle
    always @(posedge clk)
        mem_rd_data <= mem_rd_en ? word(mem_rd_addr) : $urandom();

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic monitor(input int rel);
        snap_err  = err;
        snap_busy = busy;
        if (mem_rd_en) begin
            issued++;
            if (first_rd_rel < 0) first_rd_rel = rel;
            if (exp_addr.size() == 0) check("rd_spurious", 1, 0);
            else check("rd_addr", mem_rd_addr, exp_addr.pop_front());
        end
        check("outstanding", 64'(issued - popped <= 2), 1);
        if (ready_mode == 2 && rel == 11) stall_reads = issued;
        if (a_tvalid && b_tvalid) check("both_valid", 1, 0);
        if (a_tvalid && first_av_rel < 0) first_av_rel = rel;
        if (!a_tvalid) check("a_idle", {a_tlast, a_tdata}, 0);
        if (!b_tvalid) check("b_idle", {b_tlast, b_tdata}, 0);
        if (pa_stall) check("a_hold", {a_tvalid, a_tlast, a_tdata}, pa_val);
        if (pb_stall) check("b_hold", {b_tvalid, b_tlast, b_tdata}, pb_val);
        if (b_tvalid) check("b_order", exp_a.size(), 0);
        if (a_tvalid && a_tready) begin
            popped++;
            if (exp_a.size() == 0) check("a_extra", 1, 0);
            else check("a_beat", {a_tlast, a_tdata}, exp_a.pop_front());
        end
        if (b_tvalid && b_tready) begin
            popped++;
            if (exp_b.size() == 0) check("b_extra", 1, 0);
            else check("b_beat", {b_tlast, b_tdata}, exp_b.pop_front());
        end
        pa_stall = a_tvalid && !a_tready;
        pa_val   = {a_tvalid, a_tlast, a_tdata};
        pb_stall = b_tvalid && !b_tready;
        pb_val   = {b_tvalid, b_tlast, b_tdata};
        if (!err_test) check("err_idle", err, 0);
        if (job_on && rel >= 1) check("busy", busy, 1);
        if (done) begin
            done_cnt++;
            if (job_on) begin
                done_rel = rel;
                job_on = 0;
            end
        end
    endtask

    task automatic tick();
        int rel;
        @(negedge clk);
        cyc++;
        rel = cyc - start_v;
        case (ready_mode)
            0: begin a_tready = 1'b1; b_tready = 1'b1; end
            1: begin a_tready = 1'($urandom_range(0, 1)); b_tready = 1'($urandom_range(0, 1)); end
            default: begin a_tready = (rel >= 12); b_tready = (rel >= 12); end
        endcase
        monitor(rel);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {busy, done, err, mem_rd_en, mem_rd_addr}, 0);
        check({tag, "_a"}, {a_tvalid, a_tlast, a_tdata}, 0);
        check({tag, "_b"}, {b_tvalid, b_tlast, b_tdata}, 0);
    endtask

    task automatic run_job(input int k, input logic [15:0] ab, input logic [15:0] bb,
                           input int mode, input logic [31:0] sd,
                           input int exp_done, input int abort_rel);
        seed = sd;
        ready_mode = mode;
        for (int i = 0; i < 2 * k; i++) begin
            exp_addr.push_back(ab + 16'(i));
            exp_a.push_back({(i == 2 * k - 1), word(ab + 16'(i))});
        end
        for (int i = 0; i < 2 * k; i++) begin
            exp_addr.push_back(bb + 16'(i));
            exp_b.push_back({(i == 2 * k - 1), word(bb + 16'(i))});
        end
        issued = 0; popped = 0; stall_reads = 0;
        first_rd_rel = -1; first_av_rel = -1; done_rel = -1; done_cnt = 0;
        cfg_k = 16'(k); cfg_a_base = ab; cfg_b_base = bb;
        start = 1'b1;
        start_v = cyc + 1;
        job_on = 1;
        tick();
        tick();
        // a second start and scrambled cfg while busy must both be ignored
        start = 1'b0;
        cfg_k = 16'($urandom); cfg_a_base = 16'($urandom); cfg_b_base = 16'($urandom);
        for (int t = 0; t < 6000 && done_rel < 0; t++) begin
            tick();
            if (abort_rel > 0 && cyc - start_v >= abort_rel) begin
                rst_n = 1'b0;
                job_on = 0;
                #1;
                check_reset_outputs("rst_mid");
                exp_a.delete(); exp_b.delete(); exp_addr.delete();
                pa_stall = 0; pb_stall = 0; issued = 0; popped = 0;
                tick();
                tick();
                check_reset_outputs("rst_hold");
                rst_n = 1'b1;
                tick();
                tick();
                check("rst_no_done", done_cnt, 0);
                return;
            end
        end
        if (done_rel < 0) check("done_timeout", 0, 1);
        check("busy_after", busy, 0);
        tick();
        tick();
        check("done_count", done_cnt, 1);
        check("a_left", exp_a.size(), 0);
        check("b_left", exp_b.size(), 0);
        check("addr_left", exp_addr.size(), 0);
        check("first_rd", first_rd_rel, 1);
        check("first_av", first_av_rel, 2);
        if (exp_done >= 0) check("done_cycle", done_rel, exp_done);
        if (mode == 2) check("stall_reads", 64'(stall_reads <= 2), 1);
        exp_a.delete(); exp_b.delete(); exp_addr.delete();
    endtask

    task automatic run_err(input logic [15:0] k);
        issued = 0;
        cfg_k = k;
        cfg_a_base = 16'($urandom);
        start = 1'b1;
        err_test = 1;
        tick();
        start = 1'b0;
        tick();
        check("err_pulse", snap_err, 1);
        check("err_busy", snap_busy, 0);
        tick();
        check("err_clear", snap_err, 0);
        err_test = 0;
        tick();
        tick();
        check("err_no_rd", issued, 0);
        check("err_idle_busy", busy, 0);
    endtask

    initial begin
        #1;
        check_reset_outputs("rst_init");
        tick();
        tick();
        check_reset_outputs("rst_init2");
        rst_n = 1'b1;
        tick();

        run_job(1, 16'h0010, 16'h0020, 0, 32'h0, 6, 0);
        for (int r = 0; r < 3; r++)
            run_job(4, 16'($urandom), 16'($urandom), 1, $urandom(), -1, 0);
        run_job(3, 16'($urandom), 16'($urandom), 2, $urandom(), 24, 0);
        run_err(16'd0);
        run_err(16'd65);
        run_job(2, 16'hFFFF, 16'h1234, 0, 32'h0, 10, 0);
        run_job(8, 16'h0100, 16'h0200, 0, $urandom(), -1, 6);
        run_job(2, 16'h0300, 16'h0400, 0, $urandom(), 10, 0);
        run_job(64, 16'($urandom), 16'($urandom), 1, $urandom(), -1, 0);
        for (int r = 0; r < 4; r++)
            run_job(int'($urandom_range(1, 6)), 16'($urandom), 16'($urandom), 1, $urandom(), -1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
